// File: rtl/muldiv_ctrl.sv
// MIPS-style HI/LO multiply/divide controller: single-cycle mult/multu/mthi/mtlo,
// AXI-Stream handshake to external signed/unsigned dividers. Option: MULDIV_DIVZERO_FAST_EN.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [5:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        kill,
  output logic        mdu_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_tvalid,
  input  logic        div_tready,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout_tdata,
  output logic        divu_tvalid,
  input  logic        divu_tready,
  input  logic        divu_dout_tvalid,
  input  logic [63:0] divu_dout_tdata
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_hi, r_lo, r_dividend, r_divisor;
  logic        r_signed, r_cancel, r_div_tvalid, r_divu_tvalid;

  // Op bits: {mtlo,mthi,multu,mult,divu,div}; lower bits win when several are set.
  logic w_is_div, w_is_divu, w_is_mult, w_is_multu, w_is_mthi, w_is_mtlo;
  assign w_is_div   = op[0];
  assign w_is_divu  = ~op[0] & op[1];
  assign w_is_mult  = ~|op[1:0] & op[2];
  assign w_is_multu = ~|op[2:0] & op[3];
  assign w_is_mthi  = ~|op[3:0] & op[4];
  assign w_is_mtlo  = ~|op[4:0] & op[5];

  logic w_accept, w_start_div, w_divzero;
  assign w_accept    = op_valid & ~kill & (r_state == IDLE);
  assign w_start_div = w_accept & (w_is_div | w_is_divu);

`ifdef MULDIV_DIVZERO_FAST_EN
  assign w_divzero = (src2 == 32'd0);
`else
  assign w_divzero = 1'b0;
`endif

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  assign w_prod_s = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
  assign w_prod_u = {32'd0, src1} * {32'd0, src2};

  logic        w_dout_valid, w_handshake;
  logic [63:0] w_dout_data;
  assign w_dout_valid = r_signed ? div_dout_tvalid : divu_dout_tvalid;
  assign w_dout_data  = r_signed ? div_dout_tdata  : divu_dout_tdata;
  assign w_handshake  = (r_div_tvalid & div_tready) | (r_divu_tvalid & divu_tready);

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    mdu_stall = 1'b0;
    case (r_state)
      IDLE:              mdu_stall = w_start_div;
      SEND, WAIT, DRAIN: mdu_stall = op_valid;
      default:           mdu_stall = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments so every branch reads pre-edge register values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
      r_dividend    <= 32'd0;
      r_divisor     <= 32'd0;
      r_signed      <= 1'b0;
      r_cancel      <= 1'b0;
      r_div_tvalid  <= 1'b0;
      r_divu_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_div) begin
            r_dividend <= src1;
            r_divisor  <= src2;
            r_signed   <= w_is_div;
            r_cancel   <= 1'b0;
            if (w_divzero) begin
              r_state <= DONE;
            end else begin
              r_div_tvalid  <= w_is_div;
              r_divu_tvalid <= w_is_divu;
              r_state       <= SEND;
            end
          end else if (w_accept) begin
            if (w_is_mult) begin
              r_hi <= w_prod_s[63:32];
              r_lo <= w_prod_s[31:0];
            end else if (w_is_multu) begin
              r_hi <= w_prod_u[63:32];
              r_lo <= w_prod_u[31:0];
            end else if (w_is_mthi) begin
              r_hi <= src1;
            end else if (w_is_mtlo) begin
              r_lo <= src1;
            end
          end
        end
        SEND: begin
          if (kill) r_cancel <= 1'b1;
          // A cancelled request still completes its handshake so the divider stays in sync.
          if (w_handshake) begin
            r_div_tvalid  <= 1'b0;
            r_divu_tvalid <= 1'b0;
            r_state       <= (r_cancel | kill) ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (kill) begin
            r_state <= w_dout_valid ? IDLE : DRAIN;
          end else if (w_dout_valid) begin
            r_lo    <= w_dout_data[63:32];
            r_hi    <= w_dout_data[31:0];
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cancel <= 1'b0;
          r_state  <= IDLE;
        end
        DRAIN: begin
          if (w_dout_valid) begin
            r_cancel <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hi           = r_hi;
  assign lo           = r_lo;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign div_tvalid   = r_div_tvalid;
  assign divu_tvalid  = r_divu_tvalid;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table-driven single-cycle ops plus
// hand-written divider handshake, kill, divide-by-zero and reset sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [5:0]  op;
  logic [31:0] src1, src2;
  logic        kill;
  logic        mdu_stall;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        div_tvalid, div_tready, div_dout_tvalid;
  logic [63:0] div_dout_tdata;
  logic        divu_tvalid, divu_tready, divu_dout_tvalid;
  logic [63:0] divu_dout_tdata;

  localparam logic [5:0] OP_DIV = 6'b000001, OP_DIVU = 6'b000010, OP_MULT = 6'b000100,
                         OP_MULTU = 6'b001000, OP_MTHI = 6'b010000, OP_MTLO = 6'b100000;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .kill(kill), .mdu_stall(mdu_stall), .hi(hi), .lo(lo),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_tvalid(div_tvalid), .div_tready(div_tready),
    .div_dout_tvalid(div_dout_tvalid), .div_dout_tdata(div_dout_tdata),
    .divu_tvalid(divu_tvalid), .divu_tready(divu_tready),
    .divu_dout_tvalid(divu_dout_tvalid), .divu_dout_tdata(divu_dout_tdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  // Advance one clock; inputs are then driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n_tv;
    logic ok;

    vecs[0]  = '{1'b1, OP_MULT,     32'hFFFFFFFE, 32'h00000003, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{1'b1, OP_MULTU,    32'hFFFFFFFE, 32'h00000003, 1'b0, 32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{1'b1, OP_MTHI,     32'h12345678, 32'h0,        1'b1, 32'h00000002, 32'hFFFFFFFA};
    vecs[3]  = '{1'b1, OP_MTHI,     32'h12345678, 32'h0,        1'b0, 32'h12345678, 32'hFFFFFFFA};
    vecs[4]  = '{1'b1, OP_MTLO,     32'hDEADBEEF, 32'h0,        1'b0, 32'h12345678, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, OP_MULT,     32'h00000007, 32'h00000009, 1'b1, 32'h12345678, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, OP_MULT,     32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    vecs[7]  = '{1'b1, OP_MULTU,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[8]  = '{1'b1, 6'b010100,   32'h00000005, 32'h00000006, 1'b0, 32'h00000000, 32'h0000001E};
    vecs[9]  = '{1'b1, 6'b101000,   32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE};
    vecs[10] = '{1'b1, 6'b110000,   32'h0000ABCD, 32'h0,        1'b0, 32'h0000ABCD, 32'hFFFFFFFE};
    vecs[11] = '{1'b0, OP_MULT,     32'h00000003, 32'h00000003, 1'b0, 32'h0000ABCD, 32'hFFFFFFFE};
    vecs[12] = '{1'b1, OP_MULT,     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};

    reset = 1'b1; op_valid = 1'b0; op = 6'd0; src1 = 32'd0; src2 = 32'd0; kill = 1'b0;
    div_tready = 1'b0; div_dout_tvalid = 1'b0; div_dout_tdata = 64'd0;
    divu_tready = 1'b0; divu_dout_tvalid = 1'b0; divu_dout_tdata = 64'd0;
    step(); step();
    reset = 1'b0;
    #1;
    check_hilo("reset", 32'd0, 32'd0);
    check("reset_stall", mdu_stall, 1'b0);
    check("reset_div_tvalid", div_tvalid, 1'b0);
    check("reset_divu_tvalid", divu_tvalid, 1'b0);
    check("reset_dividend", div_dividend, 32'd0);
    check("reset_divisor", div_divisor, 32'd0);

    // Single-cycle ops: no stall, HI/LO update at the next edge.
    for (int i = 0; i < 13; i++) begin
      op_valid = vecs[i].valid; op = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b;
      kill = vecs[i].kill;
      #1;
      check($sformatf("vec%0d_stall", i), mdu_stall, 1'b0);
      step();
      check_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end
    op_valid = 1'b0; kill = 1'b0;
    step();

    // div -7/2 with div|mult set: div wins; tready after 3 cycles, dout 10 cycles later.
    op_valid = 1'b1; op = 6'b000101; src1 = 32'hFFFFFFF9; src2 = 32'd2;
    #1;
    check("div_idle_stall", mdu_stall, 1'b1);
    step();
    check_hilo("div_no_mult", 32'd0, 32'd1);
    check("div_tvalid_send", div_tvalid, 1'b1);
    check("divu_tvalid_send", divu_tvalid, 1'b0);
    check("div_dividend", div_dividend, 32'hFFFFFFF9);
    check("div_divisor", div_divisor, 32'd2);
    n_tv = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) div_tready = 1'b1;
      #1;
      if (div_tvalid) n_tv++;
      step();
    end
    div_tready = 1'b0;
    check("div_tvalid_cycles", n_tv, 3);
    check("div_tvalid_after_hs", div_tvalid, 1'b0);
    ok = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (mdu_stall !== 1'b1 || lo !== 32'd1 || hi !== 32'd0) ok = 1'b0;
      step();
    end
    check("div_wait_stall_hold", ok, 1'b1);
    div_dout_tvalid = 1'b1; div_dout_tdata = {32'hFFFFFFFD, 32'hFFFFFFFF};
    step();
    div_dout_tvalid = 1'b0; div_dout_tdata = 64'd0;
    #1;
    check_hilo("div_result", 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("div_done_stall", mdu_stall, 1'b0);
    step();
    op_valid = 1'b0;
    #1;
    check("div_done_no_restart", div_tvalid, 1'b0);
    step();

    // divu 100/7 killed in WAIT: DRAIN, result discarded.
    op_valid = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7; divu_tready = 1'b1;
    step();
    check("divu_tvalid_send", divu_tvalid, 1'b1);
    check("divu_div_tvalid_off", div_tvalid, 1'b0);
    step();
    divu_tready = 1'b0;
    check("divu_tvalid_after_hs", divu_tvalid, 1'b0);
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    #1;
    check("drain_stall", mdu_stall, 1'b1);
    check_hilo("drain_kill", 32'hFFFFFFFF, 32'hFFFFFFFD);
    step(); step();
    check("drain_stall_hold", mdu_stall, 1'b1);
    divu_dout_tvalid = 1'b1; divu_dout_tdata = {32'd14, 32'd2}; op_valid = 1'b0;
    step();
    divu_dout_tvalid = 1'b0;
    check_hilo("drain_discard", 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("drain_idle_stall", mdu_stall, 1'b0);
    op_valid = 1'b1; op = OP_MTLO; src1 = 32'h55;
    step();
    op_valid = 1'b0;
    check_hilo("drain_then_mtlo", 32'hFFFFFFFF, 32'h55);

    // Kill in SEND while tready=0: tvalid holds until handshake, then DRAIN.
    op_valid = 1'b1; op = OP_DIVU; src1 = 32'd50; src2 = 32'd5;
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("send_kill_tvalid_hold", divu_tvalid, 1'b1);
    step();
    check("send_kill_tvalid_hold2", divu_tvalid, 1'b1);
    divu_tready = 1'b1;
    step();
    divu_tready = 1'b0;
    check("send_kill_tvalid_drop", divu_tvalid, 1'b0);
    check("send_kill_drain_stall", mdu_stall, 1'b1);
    divu_dout_tvalid = 1'b1; divu_dout_tdata = {32'd10, 32'd0}; op_valid = 1'b0;
    step();
    divu_dout_tvalid = 1'b0;
    check_hilo("send_kill_discard", 32'hFFFFFFFF, 32'h55);

    // Kill in WAIT with simultaneous dout: discard and return straight to IDLE.
    op_valid = 1'b1; op = OP_DIV; src1 = 32'd9; src2 = 32'd3; div_tready = 1'b1;
    step(); step();
    div_tready = 1'b0;
    kill = 1'b1; div_dout_tvalid = 1'b1; div_dout_tdata = {32'd3, 32'd0}; op_valid = 1'b0;
    step();
    kill = 1'b0; div_dout_tvalid = 1'b0;
    check_hilo("wait_kill_dout", 32'hFFFFFFFF, 32'h55);
    op_valid = 1'b1; op = OP_MTLO; src1 = 32'h66;
    step();
    op_valid = 1'b0;
    check_hilo("wait_kill_idle_mtlo", 32'hFFFFFFFF, 32'h66);

    // Divide by zero.
    op_valid = 1'b1; op = OP_DIV; src1 = 32'd5; src2 = 32'd0;
`ifdef MULDIV_DIVZERO_FAST_EN
    #1;
    check("dz_idle_stall", mdu_stall, 1'b1);
    step();
    check("dz_done_stall", mdu_stall, 1'b0);
    check("dz_no_tvalid", div_tvalid, 1'b0);
    step();
    op_valid = 1'b0;
    #1;
    check("dz_no_tvalid2", div_tvalid, 1'b0);
    check_hilo("dz_fast", 32'hFFFFFFFF, 32'h66);
`else
    div_tready = 1'b1;
    #1;
    check("dz_idle_stall", mdu_stall, 1'b1);
    step();
    check("dz_tvalid", div_tvalid, 1'b1);
    step();
    div_tready = 1'b0;
    check("dz_tvalid_drop", div_tvalid, 1'b0);
    div_dout_tvalid = 1'b1; div_dout_tdata = {32'hFFFFFFFF, 32'd5};
    step();
    div_dout_tvalid = 1'b0;
    check_hilo("dz_result", 32'd5, 32'hFFFFFFFF);
    check("dz_done_stall", mdu_stall, 1'b0);
    step();
    op_valid = 1'b0;
`endif
    step();

    // Reset mid-division; a late dout afterwards is ignored.
    op_valid = 1'b1; op = OP_DIVU; src1 = 32'd1; src2 = 32'd1; divu_tready = 1'b1;
    step(); step();
    divu_tready = 1'b0; op_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_hilo("midreset", 32'd0, 32'd0);
    check("midreset_stall", mdu_stall, 1'b0);
    check("midreset_divu_tvalid", divu_tvalid, 1'b0);
    check("midreset_dividend", div_dividend, 32'd0);
    divu_dout_tvalid = 1'b1; divu_dout_tdata = {32'hAAAAAAAA, 32'hBBBBBBBB};
    step();
    divu_dout_tvalid = 1'b0;
    check_hilo("late_dout", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous active-high.
REQ-002 SHALL have op_valid in 1: the EX-stage instruction is an MDU op; it is held stable while mdu_stall=1.
REQ-003 SHALL have op in 6, one-hot {mtlo,mthi,multu,mult,divu,div} in bits [5:0].
REQ-004 SHALL have src1 in 32 and src2 in 32: rs/dividend and rt/divisor.
REQ-005 SHALL have kill in 1: an exception is present in EX/MEM/WB this cycle.
REQ-006 SHALL have mdu_stall out 1: freeze the EX stage.
REQ-007 SHALL have hi out 32 and lo out 32: architectural HI/LO.
REQ-008 SHALL have div_dividend out 32 and div_divisor out 32, shared by both dividers.
REQ-009 SHALL have div_tvalid out 1, div_tready in 1, div_dout_tvalid in 1 and div_dout_tdata in 64 for the signed divider.
REQ-010 SHALL have divu_tvalid out 1, divu_tready in 1, divu_dout_tvalid in 1 and divu_dout_tdata in 64 for the unsigned divider.

Function
REQ-011 SHALL use states IDLE, SEND, WAIT, DONE, DRAIN.
REQ-012 IDLE SHALL handle mult/multu/mthi/mtlo with op_valid=1 and kill=0 by writing HI/LO at that clock edge, without stall: mult signed 64-bit product, multu unsigned; HI=[63:32], LO=[31:0]; mthi HI=src1; mtlo LO=src1.
REQ-013 IDLE SHALL handle div/divu with op_valid=1 and kill=0 as follows: mdu_stall=1 combinationally; register src1, src2 and the signedness flag; next state SEND.
REQ-014 SEND SHALL drive only the selected tvalid high, holding it until its tready=1, then go to WAIT; tvalid SHALL never drop before the handshake.
REQ-015 WAIT SHALL, on the selected dout_tvalid, load LO=dout_tdata[63:32] (quotient) and HI=dout_tdata[31:0] (remainder), then go to DONE.
REQ-016 DONE SHALL hold mdu_stall=0 for exactly one cycle, accept no new op, and go to IDLE.
REQ-017 mdu_stall SHALL be 1 in SEND, WAIT and DRAIN whenever op_valid=1, and 0 otherwise.
REQ-018 Kill in SEND SHALL set a cancel flag; the handshake still completes, and the block then goes to DRAIN instead of WAIT.
REQ-019 Kill in WAIT SHALL go to DRAIN; if dout_tvalid arrives in that same cycle, the result SHALL be discarded and the next state SHALL be IDLE.
REQ-020 DRAIN SHALL wait for the selected dout_tvalid, discard it (HI/LO unchanged), then go to IDLE.
REQ-021 kill=1 SHALL suppress every HI/LO write in the same cycle.
REQ-022 Divider latency SHALL be arbitrary and respected: the block SHALL NOT time out.
REQ-023 Division SHALL use 32-bit operands; results SHALL be taken unmodified from the divider, including the MIN_INT/-1 case.
REQ-024 Ops with multiple op bits set SHALL take priority div>divu>mult>multu>mthi>mtlo.

Reset
REQ-025 Reset SHALL set state=IDLE, hi=0, lo=0, div_tvalid=0, divu_tvalid=0, mdu_stall=0 (when op_valid=0), operand registers=0 and cancel flag=0.
REQ-026 Reset mid-division SHALL abandon the operation; a late dout_tvalid in IDLE SHALL be ignored.

Configuration
REQ-027 Macro MULDIV_DIVZERO_FAST_EN SHALL control divide-by-zero handling.
REQ-028 When MULDIV_DIVZERO_FAST_EN is defined, div/divu with src2=0 SHALL skip SEND/WAIT, go IDLE->DONE with mdu_stall=1 for one cycle, leave HI/LO unchanged, and assert no tvalid.
REQ-029 When MULDIV_DIVZERO_FAST_EN is not defined, divide-by-zero SHALL be issued normally, and HI/LO SHALL take the divider output.

Verification
REQ-030 A bench SHALL cover: mult 0xFFFFFFFE x 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA next edge, no stall; multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 A bench SHALL cover: div src1=-7, src2=2, tready after 3 cycles, dout after 10 -> div_tvalid held 3 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF, stall released 1 cycle after dout (DONE).
REQ-032 A bench SHALL cover: divu 100/7 with kill=1 pulsed in WAIT -> DRAIN entered, HI/LO unchanged, IDLE after dout_tvalid, stall=0 thereafter.
REQ-033 A bench SHALL cover: kill in SEND while tready=0 -> divu_tvalid stays 1 until tready, then DRAIN, HI/LO unchanged.
REQ-034 A bench SHALL cover: mthi 0x12345678 with kill=1 -> HI unchanged; then with kill=0 -> HI=0x12345678.
REQ-035 A bench SHALL cover: div by 0 with the macro defined -> no tvalid, stall exactly 1 cycle, HI/LO unchanged; without the macro -> full handshake.
